// File: rtl/grf_sb_pkg.sv
// Shared constants for the GRF hazard scoreboard: widths, forward selects,
// stage ages and the per-class Tnew/Tuse values used by the decoder.
package grf_sb_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int CW   = 2;
  localparam int TW   = 2;

  localparam logic [CW-1:0] CNT_MAX = 2'd3;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;

  localparam logic [1:0] AGE_NONE = 2'd0;
  localparam logic [1:0] AGE_E    = 2'd1;
  localparam logic [1:0] AGE_M    = 2'd2;
  localparam logic [1:0] AGE_W    = 2'd3;

  // Tnew: cycles after entering E until the result can be forwarded.
  localparam logic [TW-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TW-1:0] TNEW_LOAD = 2'd2;
  localparam logic [TW-1:0] TNEW_LINK = 2'd0;

  // Tuse: cycles until the source value is consumed.
  localparam logic [TW-1:0] TUSE_BRANCH = 2'd0;
  localparam logic [TW-1:0] TUSE_ALU    = 2'd1;
  localparam logic [TW-1:0] TUSE_STORE  = 2'd2;

  // A writer in W is covered by the GRF write-through, so it reads as GRF.
  function automatic logic [1:0] fwd_sel(input logic addr_nz,
                                         input logic [CW-1:0] cnt,
                                         input logic [1:0] age);
    if (!addr_nz || cnt == '0 || age == AGE_W)
      return FWD_GRF;
    return age;
  endfunction

endpackage

// File: rtl/grf_sb_entry.sv
// Tracking state for one architectural register: in-flight writer count,
// remaining Tnew and stage of the youngest writer.
module grf_sb_entry
  import grf_sb_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          advance,
  input  logic          issue_hit,
  input  logic [TW-1:0] issue_tnew,
  input  logic          retire_hit,
  output logic [CW-1:0] cnt,
  output logic [TW-1:0] tnew,
  output logic [1:0]    age,
  output logic          err_set
);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [TW-1:0] tnew_reg, tnew_next;
  logic [1:0]    age_reg, age_next;

  always_comb begin
    cnt_next  = cnt_reg;
    tnew_next = tnew_reg;
    age_next  = age_reg;
    err_set   = 1'b0;

    if (advance && cnt_reg != '0) begin
      if (tnew_reg != '0)
        tnew_next = tnew_reg - TW'(1);
      if (age_reg != AGE_W)
        age_next = age_reg + 2'd1;
    end

    if (issue_hit && retire_hit) begin
      // Net count is unchanged; on an empty entry the retire is bogus
      // but the new issue still lands.
      tnew_next = issue_tnew;
      age_next  = AGE_E;
      if (cnt_reg == '0) begin
        cnt_next = CW'(1);
        err_set  = 1'b1;
      end
    end else if (issue_hit) begin
      if (cnt_reg == CNT_MAX) begin
        err_set = 1'b1;
      end else begin
        cnt_next  = cnt_reg + CW'(1);
        tnew_next = issue_tnew;
        age_next  = AGE_E;
      end
    end else if (retire_hit) begin
      if (cnt_reg == '0) begin
        err_set = 1'b1;
      end else begin
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          tnew_next = '0;
          age_next  = AGE_NONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      cnt_reg  <= '0;
      tnew_reg <= '0;
      age_reg  <= AGE_NONE;
    end else begin
      cnt_reg  <= cnt_next;
      tnew_reg <= tnew_next;
      age_reg  <= age_next;
    end
  end

  assign cnt  = cnt_reg;
  assign tnew = tnew_reg;
  assign age  = age_reg;

endmodule

// File: rtl/grf_scoreboard.sv
// GRF hazard scheduler: stall and forward-select generation for D-stage sources.
// Optional stall cycle counter enabled by defining GRF_SB_STATS_EN.
module grf_scoreboard
  import grf_sb_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          advance,
  input  logic          issue_valid,
  input  logic          issue_we,
  input  logic [AW-1:0] issue_dst,
  input  logic [TW-1:0] issue_tnew,
  input  logic          rs_use,
  input  logic [AW-1:0] rs_addr,
  input  logic [TW-1:0] rs_tuse,
  input  logic          rt_use,
  input  logic [AW-1:0] rt_addr,
  input  logic [TW-1:0] rt_tuse,
  input  logic          retire_valid,
  input  logic [AW-1:0] retire_dst,
  output logic          stall,
  output logic [1:0]    rs_fwd,
  output logic [1:0]    rt_fwd,
  output logic          err
`ifdef GRF_SB_STATS_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);

  logic [CW-1:0] cnt_arr  [NREG];
  logic [TW-1:0] tnew_arr [NREG];
  logic [1:0]    age_arr  [NREG];
  logic [NREG-1:0] err_vec;

  logic issue_fire;
  logic retire_fire;
  logic hazard_rs, hazard_rt;
  logic err_reg;

  // Register 0 is hard-wired and never tracked.
  assign cnt_arr[0]  = '0;
  assign tnew_arr[0] = '0;
  assign age_arr[0]  = AGE_NONE;
  assign err_vec[0]  = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_entry
      grf_sb_entry u_entry (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .advance    (advance),
        .issue_hit  (issue_fire && issue_dst == AW'(gi)),
        .issue_tnew (issue_tnew),
        .retire_hit (retire_fire && retire_dst == AW'(gi)),
        .cnt        (cnt_arr[gi]),
        .tnew       (tnew_arr[gi]),
        .age        (age_arr[gi]),
        .err_set    (err_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    hazard_rs = rs_use && rs_addr != '0 && cnt_arr[rs_addr] != '0
                && tnew_arr[rs_addr] > rs_tuse;
    hazard_rt = rt_use && rt_addr != '0 && cnt_arr[rt_addr] != '0
                && tnew_arr[rt_addr] > rt_tuse;
    stall     = issue_valid && (hazard_rs || hazard_rt);
    rs_fwd    = fwd_sel(rs_addr != '0, cnt_arr[rs_addr], age_arr[rs_addr]);
    rt_fwd    = fwd_sel(rt_addr != '0, cnt_arr[rt_addr], age_arr[rt_addr]);
  end

  assign issue_fire  = issue_valid && issue_we && issue_dst != '0 && !stall && advance;
  assign retire_fire = retire_valid && retire_dst != '0;

  always_ff @(posedge clk) begin
    if (reset || flush)
      err_reg <= 1'b0;
    else if (|err_vec)
      err_reg <= 1'b1;
  end

  assign err = err_reg;

`ifdef GRF_SB_STATS_EN
  logic [31:0] stall_cycles_reg;

  always_ff @(posedge clk) begin
    if (reset || flush)
      stall_cycles_reg <= '0;
    else if (stall)
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
  end

  assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed self-checking bench for grf_scoreboard (stall counter checks
// are included when GRF_SB_STATS_EN is defined).
module tb_grf_scoreboard;

  logic       clk = 1'b0;
  logic       reset, flush, advance;
  logic       issue_valid, issue_we;
  logic [4:0] issue_dst;
  logic [1:0] issue_tnew;
  logic       rs_use, rt_use;
  logic [4:0] rs_addr, rt_addr;
  logic [1:0] rs_tuse, rt_tuse;
  logic       retire_valid;
  logic [4:0] retire_dst;
  logic       stall, err;
  logic [1:0] rs_fwd, rt_fwd;
`ifdef GRF_SB_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  grf_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .advance      (advance),
    .issue_valid  (issue_valid),
    .issue_we     (issue_we),
    .issue_dst    (issue_dst),
    .issue_tnew   (issue_tnew),
    .rs_use       (rs_use),
    .rs_addr      (rs_addr),
    .rs_tuse      (rs_tuse),
    .rt_use       (rt_use),
    .rt_addr      (rt_addr),
    .rt_tuse      (rt_tuse),
    .retire_valid (retire_valid),
    .retire_dst   (retire_dst),
    .stall        (stall),
    .rs_fwd       (rs_fwd),
    .rt_fwd       (rt_fwd),
    .err          (err)
`ifdef GRF_SB_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic idle();
    reset = 0; flush = 0; advance = 1;
    issue_valid = 0; issue_we = 0; issue_dst = 0; issue_tnew = 0;
    rs_use = 0; rs_addr = 0; rs_tuse = 0;
    rt_use = 0; rt_addr = 0; rt_tuse = 0;
    retire_valid = 0; retire_dst = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_issue(input logic [4:0] dst, input logic [1:0] tn);
    idle();
    issue_valid = 1; issue_we = 1; issue_dst = dst; issue_tnew = tn;
  endtask

  task automatic read_rs(input logic [4:0] a, input logic [1:0] tu);
    idle();
    issue_valid = 1; rs_use = 1; rs_addr = a; rs_tuse = tu;
  endtask

  task automatic read_rt(input logic [4:0] a, input logic [1:0] tu);
    idle();
    issue_valid = 1; rt_use = 1; rt_addr = a; rt_tuse = tu;
  endtask

  task automatic do_reset();
    idle(); reset = 1; cyc(); cyc(); idle();
  endtask

  initial begin
    idle();
    do_reset();

    read_rs(5'd1, 2'd0); rt_use = 1; rt_addr = 5'd2; settle();
    check_eq("reset_stall", stall, 0);
    check_eq("reset_rs_fwd", rs_fwd, 0);
    check_eq("reset_rt_fwd", rt_fwd, 0);
    check_eq("reset_err", err, 0);

    // lw $1 then addu reading $1 at tuse=1
    do_issue(5'd1, 2'd2); settle(); check_eq("lw_issue_stall", stall, 0); cyc();
    read_rs(5'd1, 2'd1); settle();
    check_eq("lw_use_stall", stall, 1);
    check_eq("lw_use_fwd_e", rs_fwd, 1);
    cyc(); settle();
    check_eq("lw_use_go", stall, 0);
    check_eq("lw_use_fwd_m", rs_fwd, 2);
    cyc();

    // addu $2 then beq reading $2 at tuse=0
    do_issue(5'd2, 2'd1); cyc();
    read_rt(5'd2, 2'd0); settle();
    check_eq("beq_stall", stall, 1);
    check_eq("beq_fwd_e", rt_fwd, 1);
    cyc(); settle();
    check_eq("beq_go", stall, 0);
    check_eq("beq_fwd_m", rt_fwd, 2);
    cyc();

    // writes to $0 are ignored
    do_issue(5'd0, 2'd2); settle(); check_eq("r0_issue_stall", stall, 0); cyc();
    read_rs(5'd0, 2'd0); rt_use = 1; rt_addr = 5'd0; settle();
    check_eq("r0_stall", stall, 0);
    check_eq("r0_rs_fwd", rs_fwd, 0);
    check_eq("r0_rt_fwd", rt_fwd, 0);
    check_eq("r0_err", err, 0);
    cyc();

    // $3 reaches W, then simultaneous issue + retire on $3
    do_issue(5'd3, 2'd2); cyc();
    idle(); cyc();
    idle(); cyc();
    read_rs(5'd3, 2'd0); settle();
    check_eq("w_stage_stall", stall, 0);
    check_eq("w_stage_fwd", rs_fwd, 0);
    do_issue(5'd3, 2'd1); retire_valid = 1; retire_dst = 5'd3; settle();
    check_eq("iss_ret_stall", stall, 0);
    cyc();
    read_rs(5'd3, 2'd0); settle();
    check_eq("iss_ret_reader_stall", stall, 1);
    check_eq("iss_ret_fwd_e", rs_fwd, 1);
    cyc(); settle();
    check_eq("iss_ret_reader_go", stall, 0);
    check_eq("iss_ret_fwd_m", rs_fwd, 2);
    idle(); retire_valid = 1; retire_dst = 5'd3; cyc();
    read_rs(5'd3, 2'd0); settle();
    check_eq("iss_ret_drained_fwd", rs_fwd, 0);
    check_eq("iss_ret_drained_err", err, 0);
    cyc();

    // advance=0: no aging, no issue; retire still applies
    do_issue(5'd6, 2'd2); cyc();
    read_rs(5'd6, 2'd1); advance = 0; settle();
    check_eq("hold_stall_a", stall, 1);
    check_eq("hold_fwd_a", rs_fwd, 1);
    cyc(); settle();
    check_eq("hold_stall_b", stall, 1);
    check_eq("hold_fwd_b", rs_fwd, 1);
    do_issue(5'd9, 2'd2); advance = 0; cyc();
    read_rs(5'd9, 2'd0); settle();
    check_eq("hold_no_issue_stall", stall, 0);
    check_eq("hold_no_issue_fwd", rs_fwd, 0);
    read_rs(5'd6, 2'd1); settle();
    check_eq("hold_resume_stall", stall, 1);
    cyc(); settle();
    check_eq("hold_resume_go", stall, 0);
    check_eq("hold_resume_fwd", rs_fwd, 2);
    idle(); advance = 0; retire_valid = 1; retire_dst = 5'd6; cyc();
    read_rs(5'd6, 2'd0); settle();
    check_eq("hold_retire_fwd", rs_fwd, 0);
    check_eq("hold_retire_err", err, 0);
    cyc();

    // reset mid-flight
    do_issue(5'd5, 2'd2); cyc();
    idle(); reset = 1; cyc();
    read_rs(5'd5, 2'd0); settle();
    check_eq("rst_mid_stall", stall, 0);
    check_eq("rst_mid_fwd", rs_fwd, 0);
    cyc();

    // flush mid-flight
    do_issue(5'd8, 2'd2); cyc();
    idle(); flush = 1; cyc();
    read_rt(5'd8, 2'd0); settle();
    check_eq("flush_stall", stall, 0);
    check_eq("flush_fwd", rt_fwd, 0);
    cyc();

    // retire with nothing pending: sticky error
    idle(); retire_valid = 1; retire_dst = 5'd7; settle();
    check_eq("err_before", err, 0);
    cyc(); idle(); settle();
    check_eq("err_set", err, 1);
    cyc(); cyc(); cyc(); settle();
    check_eq("err_sticky", err, 1);
    do_reset(); settle();
    check_eq("err_cleared", err, 0);

    // a fourth in-flight writer is an error
    for (int i = 0; i < 3; i++) begin
      do_issue(5'd10, 2'd0); cyc();
    end
    idle(); settle();
    check_eq("cnt3_no_err", err, 0);
    do_issue(5'd10, 2'd0); cyc(); idle(); settle();
    check_eq("cnt_overflow_err", err, 1);
    do_reset();

`ifdef GRF_SB_STATS_EN
    settle();
    check_eq("stats_reset", stall_cycles, 0);
    do_issue(5'd11, 2'd3); cyc();
    for (int i = 0; i < 4; i++) begin
      read_rs(5'd11, 2'd0); cyc();
    end
    idle(); settle();
    check_eq("stats_three", stall_cycles, 3);
    flush = 1; cyc(); idle(); settle();
    check_eq("stats_flush", stall_cycles, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Hazard scheduler for the 32x32 general register file in the 5-stage pipeline (F/D/E/M/W).
- Tracks in-flight GRF writers issued from D, asserts `stall` when a D-stage source is not yet producible, and emits per-source forward-stage selects.
- The W-stage write is treated as resolved: the GRF write-through bypass covers it, so W needs no forward select.

Parameters:
- NREG, 32, number of architectural registers; register 0 is never tracked.
- AW, 5, register address width.
- CW, 2, pending-writer count width (max 3 in flight: E, M, W).
- TW, 2, Tnew/Tuse width.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- flush, input, 1, synchronous clear of all tracking state, same effect as reset.
- advance, input, 1, pipeline E/M/W registers move this cycle.
- issue_valid, input, 1, D holds a valid instruction.
- issue_we, input, 1, instruction writes GRF.
- issue_dst, input, AW, destination register.
- issue_tnew, input, TW, cycles after entering E until result is forwardable.
- rs_use / rt_use, input, 1, source is read.
- rs_addr / rt_addr, input, AW, source registers.
- rs_tuse / rt_tuse, input, TW, cycles until the value is needed.
- retire_valid, input, 1, W-stage GRF write occurs this cycle.
- retire_dst, input, AW, register written in W.
- stall, output, 1, hold F/D and insert a bubble into E.
- rs_fwd / rt_fwd, output, 2, forward select: 0=GRF, 1=E, 2=M.
- err, output, 1, sticky protocol error.

Behaviour:
- Per-register state for registers 1..31:
  - cnt[CW]: number of in-flight writers.
  - tnew[TW]: remaining Tnew of the youngest writer.
  - age[2]: stage of the youngest writer (1=E, 2=M, 3=W).
- Reset or flush (synchronous, reset has priority): all cnt/tnew/age=0, err=0. Outputs are then stall=0, rs_fwd=rt_fwd=0.
- Hazard for rs, combinational: rs_use && rs_addr!=0 && cnt[rs]!=0 && tnew[rs] > rs_tuse. Same rule for rt.
- stall = issue_valid && (hazard_rs || hazard_rt).
- rs_fwd = 0 if rs_addr==0 or cnt[rs]==0 or age[rs]==3; otherwise age[rs]. Same rule for rt_fwd.
- Outputs are valid in the same cycle as the inputs (no latency).
- issue_fire = issue_valid && issue_we && issue_dst!=0 && !stall && advance.
- Sequential update on an advance cycle, for every register with cnt>0:
  - tnew saturating-decrements at 0.
  - age saturating-increments at 3.
- Then issue_fire sets, for issue_dst: tnew=issue_tnew, age=1, cnt+1.
- retire_valid && retire_dst!=0 decrements cnt[retire_dst]. If cnt reaches 0, tnew and age are cleared.
- Simultaneous issue and retire on the same register: cnt unchanged; tnew/age taken from the new issue.
- Retire is independent of advance.
- Error conditions set err sticky and leave cnt unchanged:
  - retire while cnt==0.
  - issue while cnt==3.
- advance=0 (e.g. an external stall): no aging and no issue; retire still applies.

Optional Feature:
- Macro GRF_SB_STATS_EN.
- Defined: adds output stall_cycles, 32-bit. It increments on every cycle where stall=1, wraps at 2^32-1 to 0, and clears on reset or flush.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - The FWD_GRF=0, FWD_E=1, FWD_M=2 encodings.
  - Stage age constants.
  - TW/AW widths.
  - The Tnew/Tuse constants per instruction class used by the decoder.
- Natural sub-module: grf_sb_entry, holding the per-register cnt/tnew/age with aging, issue and retire logic. It is instantiated 31 times; the top level does read muxing, hazard and forward logic.

Test Plan:
- lw $1 issued (tnew=2); next cycle addu reads rs=$1 with tuse=1 → stall=1 for exactly 1 cycle, then issues with rs_fwd=2.
- addu $2 (tnew=1), then beq reads rt=$2 with tuse=0 → stall=1 for 1 cycle; then rt_fwd=2 and stall=0.
- Issue with dst=$0, then read rs=$0 → stall=0, rs_fwd=0, no state change.
- $3 cnt=1 at W; same cycle issue to $3 with tnew=1 and retire $3 → cnt stays 1, age=1; reader with tuse=0 stalls.
- Pending $5 (tnew=2); assert reset mid-flight → next cycle, a read of $5 with tuse=0 gives stall=0 and rs_fwd=0.
- retire $7 with cnt=0 → err=1 and remains 1 until reset.
- With GRF_SB_STATS_EN defined: 3 stall cycles → stall_cycles=3; flush → 0.
